// File: rtl/tick_timekeeper_pkg.sv
// Shared constants and BCD helpers for the tick-driven time-of-day keeper.
package tick_timekeeper_pkg;

   localparam int         ACC_W_DEF   = 26;
   localparam int         BCD_DIGIT_W = 4;
   localparam logic [7:0] SEC_MAX     = 8'h59;
   localparam logic [7:0] MIN_MAX     = 8'h59;
   localparam logic [7:0] HOUR_MAX_24 = 8'h23;

   // Binary 0..99 to two packed BCD digits.
   function automatic logic [7:0] to_bcd2(input int unsigned v);
      return {BCD_DIGIT_W'(v / 10), BCD_DIGIT_W'(v % 10)};
   endfunction

   // True when both nibbles are decimal digits and the value does not exceed max.
   function automatic logic bcd_le(input logic [7:0] v, input logic [7:0] max);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
   endfunction

endpackage

// File: rtl/tick_timekeeper_counter.sv
// Two-digit BCD modulo counter (00..MAX) with synchronous load and carry out.
module bcd_mod_counter
   import tick_timekeeper_pkg::*;
#(
   parameter logic [7:0] MAX = SEC_MAX
) (
   input  logic       clk,
   input  logic       srst,
   input  logic       en,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic [7:0] value,
   output logic       carry_out
);

   logic [7:0]             value_q, value_d;
   logic [BCD_DIGIT_W-1:0] lo, hi;

   assign lo = value_q[BCD_DIGIT_W-1:0];
   assign hi = value_q[2*BCD_DIGIT_W-1:BCD_DIGIT_W];

   always_comb begin
      value_d = value_q;
      if (load) begin
         value_d = load_val;
      end else if (en) begin
         if (value_q == MAX)
            value_d = 8'h00;
         else if (lo == 4'd9)
            value_d = {hi + 4'd1, 4'd0};
         else
            value_d = {hi, lo + 4'd1};
      end
   end

   // A load replaces the whole time, so no carry may ripple out of it.
   assign carry_out = en && !load && (value_q == MAX);
   assign value     = value_q;

   always_ff @(posedge clk) begin
      if (srst)
         value_q <= 8'h00;
      else
         value_q <= value_d;
   end

endmodule

// File: rtl/tick_timekeeper.sv
// Detects phase-accumulator wrap-arounds as one-second ticks and keeps a BCD HH:MM:SS clock.
module tick_timekeeper
   import tick_timekeeper_pkg::*;
#(
   parameter int ACC_W    = ACC_W_DEF,
   parameter int HOUR_MAX = 23
) (
   input  logic             clk,
   input  logic             GlobalReset,
   input  logic [ACC_W-1:0] acc_in,
   input  logic             set_valid,
   input  logic [7:0]       set_hh,
   input  logic [7:0]       set_mm,
   input  logic [7:0]       set_ss,
   output logic             sec_tick,
   output logic [7:0]       hh_bcd,
   output logic [7:0]       mm_bcd,
   output logic [7:0]       ss_bcd,
   output logic             day_roll,
   output logic             set_err
);

   localparam logic [7:0] HOUR_MAX_BCD = to_bcd2(HOUR_MAX);

   logic [ACC_W-1:0] prev_acc_q, prev_acc_d;
   logic             sec_tick_q, sec_tick_d;
   logic             day_roll_q, day_roll_d;
   logic             set_err_q, set_err_d;
   logic             load_ok, load_en;
   logic             ss_carry, mm_carry, hh_carry;

   always_comb begin
      load_ok    = bcd_le(set_ss, SEC_MAX) && bcd_le(set_mm, MIN_MAX) &&
                   bcd_le(set_hh, HOUR_MAX_BCD);
      load_en    = set_valid && load_ok;
      prev_acc_d = acc_in;
      sec_tick_d = (acc_in < prev_acc_q);
      set_err_d  = set_valid && !load_ok;
      day_roll_d = hh_carry;
   end

   // The registered tick drives the counter, so time moves one edge after the wrap is seen.
   bcd_mod_counter #(.MAX(SEC_MAX)) u_ss (
      .clk(clk), .srst(GlobalReset), .en(sec_tick_q), .load(load_en),
      .load_val(set_ss), .value(ss_bcd), .carry_out(ss_carry)
   );

   bcd_mod_counter #(.MAX(MIN_MAX)) u_mm (
      .clk(clk), .srst(GlobalReset), .en(ss_carry), .load(load_en),
      .load_val(set_mm), .value(mm_bcd), .carry_out(mm_carry)
   );

   bcd_mod_counter #(.MAX(HOUR_MAX_BCD)) u_hh (
      .clk(clk), .srst(GlobalReset), .en(mm_carry), .load(load_en),
      .load_val(set_hh), .value(hh_bcd), .carry_out(hh_carry)
   );

   always_ff @(posedge clk) begin
      if (GlobalReset) begin
         prev_acc_q <= '0;
         sec_tick_q <= 1'b0;
         day_roll_q <= 1'b0;
         set_err_q  <= 1'b0;
      end else begin
         prev_acc_q <= prev_acc_d;
         sec_tick_q <= sec_tick_d;
         day_roll_q <= day_roll_d;
         set_err_q  <= set_err_d;
      end
   end

   assign sec_tick = sec_tick_q;
   assign day_roll = day_roll_q;
   assign set_err  = set_err_q;

endmodule

// File: doc/tick_timekeeper.md
Name: tick_timekeeper

Overview:
- Downstream consumer of the 26-bit phase accumulator output.
- Treats the accumulator as an NCO and detects each wrap-around of its value as one timebase tick.
- Counts ticks into a BCD HH:MM:SS time-of-day with a synchronous load port.
- Drives the display/compare stages that follow.

Parameters:
- ACC_W, 26, width of the accumulator value consumed; must match the accumulator width.
- HOUR_MAX, 23, last valid hour value; the hour field wraps to 00 after it (23 selects 24-hour mode).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- GlobalReset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- acc_in  input  ACC_W  accumulator output; a new value each cycle.
- set_valid  input  1  one-cycle load strobe for set_hh, set_mm and set_ss.
- set_hh  input  8  BCD hours to load.
- set_mm  input  8  BCD minutes to load.
- set_ss  input  8  BCD seconds to load.
- sec_tick  output  1  one-cycle pulse per detected accumulator wrap.
- hh_bcd  output  8  current hours, BCD.
- mm_bcd  output  8  current minutes, BCD.
- ss_bcd  output  8  current seconds, BCD.
- day_roll  output  1  one-cycle pulse when the time advances from HOUR_MAX:59:59 to 00:00:00.
- set_err  output  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset, while GlobalReset=1 at an edge:
  - prev_acc=0, sec_tick=0, day_roll=0, set_err=0.
  - hh_bcd, mm_bcd and ss_bcd all 8'h00.
  - Reset overrides every other input.
- Wrap detect, every cycle:
  - wrap = (acc_in < prev_acc), unsigned compare.
  - prev_acc <= acc_in.
  - acc_in == prev_acc is not a wrap.
  - The first cycle after reset cannot wrap because prev_acc=0.
- Tick latency:
  - A wrap detected on the acc_in sampled at edge N gives sec_tick=1 during cycle N..N+1, i.e. registered, 1-cycle latency.
  - sec_tick is never high two cycles in a row unless acc_in wraps on consecutive samples.
- Count: at the edge where sec_tick=1, the time advances by one second.
  - Seconds: ss 00..59, BCD digit-wise; low digit 9 -> 0 with carry; 59 -> 00 with carry to minutes.
  - Minutes: mm 00..59, same rule; 59 -> 00 with carry to hours.
  - Hours: hh 00..HOUR_MAX; HOUR_MAX -> 00.
  - day_roll is asserted for the one cycle after the edge that produces 00:00:00 from HOUR_MAX:59:59.
  - In total, a wrap sampled at edge N updates the BCD outputs at edge N+1.
- Load:
  - A load is valid only if all of:
    - every nibble is <= 9;
    - ss <= 8'h59;
    - mm <= 8'h59;
    - hh <= HOUR_MAX in BCD.
  - Valid load: the fields are loaded at that edge and seen on the outputs next cycle.
  - Invalid load: state is unchanged and set_err=1 for one cycle.
- Simultaneous events:
  - set_valid and sec_tick at the same edge: the load wins and that tick's increment is discarded; sec_tick still pulses.
  - A rejected load does not suppress the tick.
- GlobalReset mid-count: everything returns to the reset values at the next edge, and any pending tick is dropped.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package holds:
  - ACC_W default (26);
  - BCD digit width (4);
  - constants SEC_MAX=8'h59, MIN_MAX=8'h59, HOUR_MAX_24=8'h23.
- One natural sub-module, bcd_mod_counter:
  - 2-digit BCD counter with a MAX parameter.
  - Ports: en, load, load_val, carry_out.
  - Instantiated three times for ss, mm and hh.

Test Plan:
- Reset then free-run: GlobalReset=1 for 2 cycles, acc_in ramping 0,1,2,... -> outputs 00:00:00, sec_tick never asserts.
- Single wrap: acc_in = 26'h3FFFFF0 then 26'h0000005 -> sec_tick=1 exactly one cycle later, ss_bcd=8'h01 the cycle after.
- BCD carry: load 00:00:09, one wrap -> 00:00:10; load 00:59:59, one wrap -> 01:00:00.
- Day rollover: load 23:59:59, one wrap -> 00:00:00 with day_roll=1 for one cycle.
- Invalid loads:
  - set_ss=8'h60 -> set_err=1 for one cycle, time unchanged.
  - set_hh=8'h24 -> same result.
  - set_mm=8'h1A -> same result.
- Collision and reset: set_valid with 12:34:56 on the tick edge -> 12:34:56, no increment; GlobalReset asserted at 05:06:07 mid-run -> 00:00:00 next cycle, sec_tick=0.
